// File: rtl/mem_stage.sv
// Memory stage of an in-order pipeline.
// Accepts one EX result at a time. ALU ops and misaligned accesses retire in
// the next cycle. Aligned loads and stores issue a single bus request and wait
// for grant then response before writing back.
//
// Handshake rules: a transfer from EX happens on a rising edge where
// ex_valid_i && ex_ready_o; a bus request is consumed on a rising edge where
// data_req_o && data_gnt_i; a response is consumed on a rising edge where
// data_rvalid_i is high while waiting for it; anything else on those inputs is
// ignored.
module mem_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic        reg_we_i,
    input  logic [4:0]  wr_addr_i,
    input  logic [31:0] rd_wdata_i,
    input  logic [1:0]  mem_op_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [31:0] store_data_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic        data_we_o,
    output logic [31:0] data_addr_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_wdata_o,
    output logic        misalign_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Fields of the accepted op needed once the bus response arrives
    logic        r_ld_we;
    logic [4:0]  r_ld_waddr;
    logic [1:0]  r_ld_off;
    logic [1:0]  r_ld_size;
    logic        r_ld_unsigned;
    logic        r_is_store;

    // Registered bus and writeback outputs
    logic        r_data_req;
    logic        r_data_we;
    logic [31:0] r_data_addr;
    logic [3:0]  r_data_be;
    logic [31:0] r_data_wdata;
    logic        r_wb_valid;
    logic        r_wb_we;
    logic [4:0]  r_wb_addr;
    logic [31:0] r_wb_wdata;
    logic        r_misalign;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    assign w_accept = ex_valid_i && (r_state == S_IDLE);
    // Op encoding 11 behaves like "no memory access"
    assign w_is_mem = (mem_op_i == 2'b01) || (mem_op_i == 2'b10);

    // Alignment check, byte enables and lane-replicated store data for the incoming op
    always_comb begin
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = store_data_i;
        case (mem_size_i)
            2'b00: begin
                w_be    = 4'b0001 << rd_wdata_i[1:0];
                w_wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                w_misaligned = rd_wdata_i[0];
                w_be         = 4'b0011 << rd_wdata_i[1:0];
                w_wdata      = {2{store_data_i[15:0]}};
            end
            default: begin
                w_misaligned = |rd_wdata_i[1:0];
            end
        endcase
    end

    // Move the addressed bytes to the bottom, then truncate and extend per size/signedness
    assign w_shifted = data_rdata_i >> {r_ld_off, 3'b000};
    always_comb begin
        w_load_data = w_shifted;
        case (r_ld_size)
            2'b00:   w_load_data = r_ld_unsigned ? {24'h0, w_shifted[7:0]}
                                                 : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_data = r_ld_unsigned ? {16'h0, w_shifted[15:0]}
                                                 : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // Next-state logic: only aligned memory ops leave IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && w_is_mem && !w_misaligned) w_next_state = S_REQ;
            S_REQ:    if (data_gnt_i) w_next_state = S_WAIT_R;
            S_WAIT_R: if (data_rvalid_i) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Capture accepted op, drive bus request, and produce writeback/misalign pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ld_we       <= 1'b0;
            r_ld_waddr    <= 5'd0;
            r_ld_off      <= 2'd0;
            r_ld_size     <= 2'd0;
            r_ld_unsigned <= 1'b0;
            r_is_store    <= 1'b0;
            r_data_req    <= 1'b0;
            r_data_we     <= 1'b0;
            r_data_addr   <= 32'd0;
            r_data_be     <= 4'd0;
            r_data_wdata  <= 32'd0;
            r_wb_valid    <= 1'b0;
            r_wb_we       <= 1'b0;
            r_wb_addr     <= 5'd0;
            r_wb_wdata    <= 32'd0;
            r_misalign    <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;
            if (w_accept) begin
                r_ld_we       <= reg_we_i;
                r_ld_waddr    <= wr_addr_i;
                r_ld_off      <= rd_wdata_i[1:0];
                r_ld_size     <= mem_size_i;
                r_ld_unsigned <= mem_unsigned_i;
                r_is_store    <= (mem_op_i == 2'b10);
                if (!w_is_mem) begin
                    r_wb_valid <= 1'b1;
                    r_wb_we    <= reg_we_i;
                    r_wb_addr  <= wr_addr_i;
                    r_wb_wdata <= rd_wdata_i;
                end else if (w_misaligned) begin
                    r_wb_valid <= 1'b1;
                    r_wb_we    <= 1'b0;
                    r_misalign <= 1'b1;
                end else begin
                    r_data_req   <= 1'b1;
                    r_data_we    <= (mem_op_i == 2'b10);
                    r_data_addr  <= {rd_wdata_i[31:2], 2'b00};
                    r_data_be    <= w_be;
                    r_data_wdata <= w_wdata;
                end
            end
            if ((r_state == S_REQ) && data_gnt_i) begin
                r_data_req <= 1'b0;
            end
            if ((r_state == S_WAIT_R) && data_rvalid_i) begin
                r_wb_valid <= 1'b1;
                if (r_is_store) begin
                    r_wb_we <= 1'b0;
                end else begin
                    r_wb_we    <= r_ld_we;
                    r_wb_addr  <= r_ld_waddr;
                    r_wb_wdata <= w_load_data;
                end
            end
        end
    end

    assign ex_ready_o   = (r_state == S_IDLE);
    assign data_req_o   = r_data_req;
    assign data_we_o    = r_data_we;
    assign data_addr_o  = r_data_addr;
    assign data_be_o    = r_data_be;
    assign data_wdata_o = r_data_wdata;
    assign wb_valid_o   = r_wb_valid;
    assign wb_we_o      = r_wb_we;
    assign wb_addr_o    = r_wb_addr;
    assign wb_wdata_o   = r_wb_wdata;
    assign misalign_o   = r_misalign;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// multi-cycle sequences, and randomized transactions checked against a
// byte-level reference model through a writeback scoreboard.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic        reg_we_i = 1'b0;
    logic [4:0]  wr_addr_i = 5'd0;
    logic [31:0] rd_wdata_i = 32'd0;
    logic [1:0]  mem_op_i = 2'd0;
    logic [1:0]  mem_size_i = 2'd0;
    logic        mem_unsigned_i = 1'b0;
    logic [31:0] store_data_i = 32'd0;
    logic        data_req_o;
    logic        data_gnt_i = 1'b0;
    logic        data_we_o;
    logic [31:0] data_addr_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = 32'd0;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_wdata_o;
    logic        misalign_o;
    logic [1:0]  dbg_state_o;

    int n_checks = 0;
    int n_errors = 0;
    bit sb_en = 1'b0;
    logic [37:0] exp_q[$];   // {we, addr, data} of expected writebacks

    mem_stage dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ex_valid_i     (ex_valid_i),
        .ex_ready_o     (ex_ready_o),
        .reg_we_i       (reg_we_i),
        .wr_addr_i      (wr_addr_i),
        .rd_wdata_i     (rd_wdata_i),
        .mem_op_i       (mem_op_i),
        .mem_size_i     (mem_size_i),
        .mem_unsigned_i (mem_unsigned_i),
        .store_data_i   (store_data_i),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_we_o      (data_we_o),
        .data_addr_o    (data_addr_o),
        .data_be_o      (data_be_o),
        .data_wdata_o   (data_wdata_o),
        .data_rvalid_i  (data_rvalid_i),
        .data_rdata_i   (data_rdata_i),
        .wb_valid_o     (wb_valid_o),
        .wb_we_o        (wb_we_o),
        .wb_addr_o      (wb_addr_o),
        .wb_wdata_o     (wb_wdata_o),
        .misalign_o     (misalign_o),
        .dbg_state_o    (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [1:0] sz);
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input int off, input int nb);
        logic [3:0] be;
        be = 4'd0;
        for (int b = 0; b < 4; b++) be[b] = (b >= off) && (b < off + nb);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] sd, input int nb);
        logic [31:0] w;
        w = 32'd0;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = sd[8*(b % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input int off,
                                               input int nb, input bit uns);
        longint v;
        longint byte_v;
        v = 0;
        for (int i = 0; i < nb; i++) begin
            byte_v = longint'((rdata >> (8 * (off + i))) & 32'hFF);
            v = v + (byte_v << (8 * i));
        end
        if (!uns && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (sb_en && !rst && wb_valid_o) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_wb", 32'd1, 32'd0);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                check("sb_wb_we", {31'd0, wb_we_o}, {31'd0, e[37]});
                if (e[37]) begin
                    check("sb_wb_addr", {27'd0, wb_addr_o}, {27'd0, e[36:32]});
                    check("sb_wb_data", wb_wdata_o, e[31:0]);
                end
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic        uns;
        logic        reg_we;
        logic [4:0]  wr;
        logic [31:0] ea;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic        exp_mis;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_bus_wdata;
        logic        exp_wb_we;
        logic [31:0] exp_wb_data;
    } vec_t;

    vec_t vecs[13];

    task automatic drive_op(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                            input logic rwe, input logic [4:0] wr, input logic [31:0] ea,
                            input logic [31:0] sd);
        ex_valid_i     = 1'b1;
        mem_op_i       = op;
        mem_size_i     = sz;
        mem_unsigned_i = uns;
        reg_we_i       = rwe;
        wr_addr_i      = wr;
        rd_wdata_i     = ea;
        store_data_i   = sd;
    endtask

    task automatic run_vec(input vec_t v);
        bit is_mem;
        is_mem = (v.op == 2'd1) || (v.op == 2'd2);
        drive_op(v.op, v.size, v.uns, v.reg_we, v.wr, v.ea, v.sd);
        check("vec_ready_before", {31'd0, ex_ready_o}, 32'd1);
        tick();
        ex_valid_i = 1'b0;
        if (v.exp_mis) begin
            check("vec_mis_pulse", {31'd0, misalign_o}, 32'd1);
            check("vec_mis_wb_valid", {31'd0, wb_valid_o}, 32'd1);
            check("vec_mis_wb_we", {31'd0, wb_we_o}, 32'd0);
            check("vec_mis_no_req", {31'd0, data_req_o}, 32'd0);
            tick();
            check("vec_mis_pulse_end", {31'd0, misalign_o}, 32'd0);
            check("vec_mis_no_req2", {31'd0, data_req_o}, 32'd0);
        end else if (!is_mem) begin
            check("vec_alu_wb_valid", {31'd0, wb_valid_o}, 32'd1);
            check("vec_alu_wb_we", {31'd0, wb_we_o}, {31'd0, v.exp_wb_we});
            check("vec_alu_wb_addr", {27'd0, wb_addr_o}, {27'd0, v.wr});
            check("vec_alu_wb_data", wb_wdata_o, v.exp_wb_data);
            check("vec_alu_no_req", {31'd0, data_req_o}, 32'd0);
        end else begin
            check("vec_req", {31'd0, data_req_o}, 32'd1);
            check("vec_addr", data_addr_o, v.exp_addr);
            check("vec_be", {28'd0, data_be_o}, {28'd0, v.exp_be});
            check("vec_bus_wdata", data_wdata_o, v.exp_bus_wdata);
            check("vec_bus_we", {31'd0, data_we_o}, {31'd0, (v.op == 2'd2)});
            check("vec_not_ready", {31'd0, ex_ready_o}, 32'd0);
            for (int i = 0; i < 2; i++) begin
                tick();
                check("vec_req_held", {31'd0, data_req_o}, 32'd1);
                check("vec_addr_held", data_addr_o, v.exp_addr);
            end
            data_gnt_i = 1'b1;
            tick();
            data_gnt_i = 1'b0;
            check("vec_req_dropped", {31'd0, data_req_o}, 32'd0);
            check("vec_wait_not_ready", {31'd0, ex_ready_o}, 32'd0);
            tick();
            check("vec_no_early_wb", {31'd0, wb_valid_o}, 32'd0);
            data_rvalid_i = 1'b1;
            data_rdata_i  = v.rdata;
            tick();
            data_rvalid_i = 1'b0;
            check("vec_mem_wb_valid", {31'd0, wb_valid_o}, 32'd1);
            check("vec_mem_wb_we", {31'd0, wb_we_o}, {31'd0, v.exp_wb_we});
            if (v.exp_wb_we) begin
                check("vec_load_data", wb_wdata_o, v.exp_wb_data);
                check("vec_load_addr", {27'd0, wb_addr_o}, {27'd0, v.wr});
            end
            check("vec_ready_after", {31'd0, ex_ready_o}, 32'd1);
        end
        tick();
        check("vec_wb_pulse_end", {31'd0, wb_valid_o}, 32'd0);
    endtask

    // ---------------- main test ----------------
    initial begin
        logic [1:0]  op, sz;
        logic        uns, rwe;
        logic [4:0]  wr;
        logic [31:0] ea, sd, rd;
        int          off, nb, g;
        bit          is_mem, mis;

        //        op    size  uns   we    wr     ea            sd            rdata         mis   addr          be       bus_wdata     wbwe  wb_data
        vecs[0]  = '{2'd0, 2'd2, 1'b0, 1'b1, 5'd5,  32'h0000_1234, 32'h0,        32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000_1234};
        vecs[1]  = '{2'd1, 2'd0, 1'b0, 1'b1, 5'd7,  32'h0000_0103, 32'h0,        32'h80FF_FF7F, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        1'b1, 32'hFFFF_FF80};
        vecs[2]  = '{2'd2, 2'd1, 1'b0, 1'b1, 5'd3,  32'h0000_0202, 32'hDEAD_BEEF, 32'h0,        1'b0, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0};
        vecs[3]  = '{2'd1, 2'd2, 1'b0, 1'b1, 5'd4,  32'h0000_0301, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[4]  = '{2'd1, 2'd1, 1'b1, 1'b1, 5'd8,  32'h0000_0402, 32'h0,        32'h9ABC_0000, 1'b0, 32'h0000_0400, 4'b1100, 32'h0,        1'b1, 32'h0000_9ABC};
        vecs[5]  = '{2'd1, 2'd1, 1'b0, 1'b1, 5'd9,  32'h0000_0402, 32'h0,        32'h9ABC_0000, 1'b0, 32'h0000_0400, 4'b1100, 32'h0,        1'b1, 32'hFFFF_9ABC};
        vecs[6]  = '{2'd1, 2'd0, 1'b1, 1'b1, 5'd10, 32'h0000_0101, 32'h0,        32'h0000_A500, 1'b0, 32'h0000_0100, 4'b0010, 32'h0,        1'b1, 32'h0000_00A5};
        vecs[7]  = '{2'd2, 2'd0, 1'b0, 1'b0, 5'd0,  32'h0000_0503, 32'h1234_56AB, 32'h0,        1'b0, 32'h0000_0500, 4'b1000, 32'hABAB_ABAB, 1'b0, 32'h0};
        vecs[8]  = '{2'd2, 2'd2, 1'b0, 1'b0, 5'd0,  32'h0000_0600, 32'hCAFE_F00D, 32'h0,        1'b0, 32'h0000_0600, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[9]  = '{2'd3, 2'd0, 1'b0, 1'b0, 5'd9,  32'h0000_55AA, 32'h0,        32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0000_55AA};
        vecs[10] = '{2'd2, 2'd1, 1'b0, 1'b0, 5'd0,  32'h0000_0701, 32'h0000_1111, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[11] = '{2'd1, 2'd3, 1'b1, 1'b1, 5'd11, 32'h0000_0800, 32'h0,        32'h8765_4321, 1'b0, 32'h0000_0800, 4'b1111, 32'h0,        1'b1, 32'h8765_4321};
        vecs[12] = '{2'd1, 2'd0, 1'b0, 1'b1, 5'd12, 32'h0000_07F2, 32'h0,        32'h0042_0000, 1'b0, 32'h0000_07F0, 4'b0100, 32'h0,        1'b1, 32'h0000_0042};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_ready", {31'd0, ex_ready_o}, 32'd1);
        check("rst_req", {31'd0, data_req_o}, 32'd0);
        check("rst_we", {31'd0, data_we_o}, 32'd0);
        check("rst_addr", data_addr_o, 32'd0);
        check("rst_be", {28'd0, data_be_o}, 32'd0);
        check("rst_bus_wdata", data_wdata_o, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        check("rst_wb_we", {31'd0, wb_we_o}, 32'd0);
        check("rst_wb_addr", {27'd0, wb_addr_o}, 32'd0);
        check("rst_wb_data", wb_wdata_o, 32'd0);
        check("rst_misalign", {31'd0, misalign_o}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, ex_ready_o}, 32'd1);

        // Directed vectors
        foreach (vecs[i]) run_vec(vecs[i]);

        // Three back-to-back ALU ops retire one per cycle
        drive_op(2'd0, 2'd2, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b_wb_valid", {31'd0, wb_valid_o}, 32'd1);
            check("b2b_wb_data", wb_wdata_o, 32'h0000_1234);
            check("b2b_wb_addr", {27'd0, wb_addr_o}, 32'd5);
            check("b2b_no_req", {31'd0, data_req_o}, 32'd0);
            check("b2b_ready", {31'd0, ex_ready_o}, 32'd1);
        end
        ex_valid_i = 1'b0;
        tick();
        check("b2b_pulse_end", {31'd0, wb_valid_o}, 32'd0);

        // Stray grant/response while idle is ignored
        data_gnt_i    = 1'b1;
        data_rvalid_i = 1'b1;
        tick();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        check("idle_stray_wb", {31'd0, wb_valid_o}, 32'd0);
        check("idle_stray_req", {31'd0, data_req_o}, 32'd0);
        check("idle_stray_ready", {31'd0, ex_ready_o}, 32'd1);

        // Response during REQ is ignored; request stays up
        drive_op(2'd1, 2'd2, 1'b0, 1'b1, 5'd6, 32'h0000_0900, 32'h0);
        tick();
        ex_valid_i    = 1'b0;
        data_rvalid_i = 1'b1;
        tick();
        data_rvalid_i = 1'b0;
        check("req_rvalid_ignored_wb", {31'd0, wb_valid_o}, 32'd0);
        check("req_rvalid_ignored_req", {31'd0, data_req_o}, 32'd1);

        // Reset while waiting for the response abandons the access
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        check("wait_not_ready", {31'd0, ex_ready_o}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wait_rst_ready", {31'd0, ex_ready_o}, 32'd1);
        check("wait_rst_req", {31'd0, data_req_o}, 32'd0);
        check("wait_rst_wb", {31'd0, wb_valid_o}, 32'd0);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h1111_2222;
        tick();
        data_rvalid_i = 1'b0;
        check("late_rvalid_wb", {31'd0, wb_valid_o}, 32'd0);
        check("late_rvalid_ready", {31'd0, ex_ready_o}, 32'd1);
        tick();
        check("late_rvalid_wb2", {31'd0, wb_valid_o}, 32'd0);

        // Randomized transactions against the reference model
        sb_en = 1'b1;
        for (int t = 0; t < 150; t++) begin
            op  = 2'($urandom_range(0, 3));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            rwe = 1'($urandom_range(0, 1));
            wr  = 5'($urandom_range(0, 31));
            ea  = $urandom;
            sd  = $urandom;
            nb  = size_bytes(sz);
            if ($urandom_range(0, 2) != 0) ea = ea & ~(32'(nb) - 32'd1);
            off    = int'(ea[1:0]);
            is_mem = (op == 2'd1) || (op == 2'd2);
            mis    = is_mem && ((off % nb) != 0);
            drive_op(op, sz, uns, rwe, wr, ea, sd);
            tick();
            ex_valid_i = 1'b0;
            if (!is_mem) begin
                exp_q.push_back({rwe, wr, ea});
                check("rnd_alu_no_req", {31'd0, data_req_o}, 32'd0);
            end else if (mis) begin
                exp_q.push_back({1'b0, wr, 32'd0});
                check("rnd_mis_pulse", {31'd0, misalign_o}, 32'd1);
                check("rnd_mis_no_req", {31'd0, data_req_o}, 32'd0);
            end else begin
                check("rnd_req", {31'd0, data_req_o}, 32'd1);
                check("rnd_addr", data_addr_o, ea & 32'hFFFF_FFFC);
                check("rnd_be", {28'd0, data_be_o}, {28'd0, model_be(off, nb)});
                check("rnd_bus_wdata", data_wdata_o, model_wdata(sd, nb));
                check("rnd_bus_we", {31'd0, data_we_o}, {31'd0, (op == 2'd2)});
                g = $urandom_range(0, 3);
                for (int i = 0; i < g; i++) begin
                    data_rvalid_i = 1'($urandom_range(0, 1));
                    tick();
                    check("rnd_req_held", {31'd0, data_req_o}, 32'd1);
                    check("rnd_req_not_ready", {31'd0, ex_ready_o}, 32'd0);
                end
                data_rvalid_i = 1'b0;
                data_gnt_i    = 1'b1;
                tick();
                data_gnt_i = 1'b0;
                check("rnd_req_dropped", {31'd0, data_req_o}, 32'd0);
                g = $urandom_range(0, 3);
                for (int i = 0; i < g; i++) begin
                    data_gnt_i = 1'($urandom_range(0, 1));
                    tick();
                    check("rnd_wait_no_req", {31'd0, data_req_o}, 32'd0);
                end
                data_gnt_i    = 1'b0;
                rd            = $urandom;
                data_rdata_i  = rd;
                data_rvalid_i = 1'b1;
                if (op == 2'd1) exp_q.push_back({rwe, wr, model_load(rd, off, nb, uns)});
                else            exp_q.push_back({1'b0, wr, 32'd0});
                tick();
                data_rvalid_i = 1'b0;
                check("rnd_ready_after", {31'd0, ex_ready_o}, 32'd1);
            end
            if ($urandom_range(0, 3) == 0) tick();
        end
        tick();
        tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        sb_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
